// File: rtl/opb_pkg.sv
// opb_slave_mux shared definitions.
// Bus widths, FSM state encoding and error counter width.
package opb_pkg;

  localparam int AWIDTH = 32;
  localparam int DWIDTH = 32;
  localparam int ECW    = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } opb_state_e;

endpackage

// File: rtl/opb_addr_decode.sv
// opb_slave_mux address decoder.
// Window hit test and slave index extraction, purely combinational.
module opb_addr_decode
  import opb_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0000,
  parameter int          C_NUM_SLAVES = 4,
  parameter int          C_SPAN_LOG2  = 8
) (
  input  logic [0:AWIDTH-1] abus,
  output logic              hit,
  output logic [3:0]        idx,
  output logic              idx_valid
);

  logic [AWIDTH-1:0] addr;
  logic [AWIDTH-1:0] idx_sh;

  // Bit 0 of the bus is the MSB, so a packed copy keeps the numeric value.
  assign addr   = abus;
  assign idx_sh = addr >> C_SPAN_LOG2;

  // Upper bits above the index field must match the base.
  always_comb begin
    hit       = (addr >> (C_SPAN_LOG2 + 4)) ==
                (C_BASEADDR >> (C_SPAN_LOG2 + 4));
    idx       = idx_sh[3:0];
    idx_valid = ({28'd0, idx_sh[3:0]} < 32'(C_NUM_SLAVES));
  end

endmodule

// File: rtl/opb_slave_mux.sv
// opb_slave_mux top level.
// Select FSM, ack timeout, read data return and error counter.
module opb_slave_mux
  import opb_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0000,
  parameter int          C_NUM_SLAVES = 4,
  parameter int          C_SPAN_LOG2  = 8,
  parameter int          C_TIMEOUT    = 12
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:AWIDTH-1]          OPB_ABus,
  input  logic                       OPB_select,
  input  logic                       OPB_RNW,
  output logic [0:DWIDTH-1]          Sl_DBus,
  output logic                       Sl_xferAck,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic [C_NUM_SLAVES-1:0]    S_select,
  input  logic [C_NUM_SLAVES*32-1:0] S_DBus,
  input  logic [C_NUM_SLAVES-1:0]    S_xferAck,
  output logic [ECW-1:0]             err_cnt
);

  opb_state_e state, state_n;

  logic [3:0]              cnt, cnt_n;
  logic [3:0]              idx_q, idx_n;
  logic [C_NUM_SLAVES-1:0] sel_n, sel_hot;
  logic [DWIDTH-1:0]       dbus_n, rd_data;
  logic                    xack_n, eack_n, tsup_n;
  logic [ECW-1:0]          ecnt_n, ecnt_inc;
  logic [15:0]             ack_pad;
  logic                    hit, idx_valid;
  logic [3:0]              dec_idx;
  logic                    tmo;

  opb_addr_decode #(
    .C_BASEADDR   (C_BASEADDR),
    .C_NUM_SLAVES (C_NUM_SLAVES),
    .C_SPAN_LOG2  (C_SPAN_LOG2)
  ) u_dec (
    .abus      (OPB_ABus),
    .hit       (hit),
    .idx       (dec_idx),
    .idx_valid (idx_valid)
  );

  assign Sl_retry = 1'b0;

  // Slave-side muxing: one-hot select, latched-slave data and ack.
  always_comb begin
    sel_hot = '0;
    rd_data = '0;
    ack_pad = '0;
    ack_pad[C_NUM_SLAVES-1:0] = S_xferAck;
    for (int k = 0; k < C_NUM_SLAVES; k++) begin
      sel_hot[k] = (dec_idx == 4'(k));
      if (idx_q == 4'(k)) rd_data = S_DBus[32*k +: 32];
    end
  end

  assign tmo      = (({1'b0, cnt} + 5'd1) == 5'(C_TIMEOUT));
  assign ecnt_inc = (&err_cnt) ? err_cnt : err_cnt + 1'b1;

  // Next state and next values of all registered outputs.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx_q;
    sel_n   = S_select;
    dbus_n  = '0;
    xack_n  = 1'b0;
    eack_n  = 1'b0;
    ecnt_n  = err_cnt;
    unique case (state)
      IDLE: begin
        if (OPB_select && hit) begin
          if (idx_valid) begin
            idx_n   = dec_idx;
            sel_n   = sel_hot;
            cnt_n   = '0;
            state_n = ACTIVE;
          end else begin
            eack_n  = 1'b1;
            ecnt_n  = ecnt_inc;
            state_n = DONE;
          end
        end
      end
      ACTIVE: begin
        if (!OPB_select) begin
          sel_n   = '0;
          state_n = IDLE;
        end else if (ack_pad[idx_q]) begin
          dbus_n  = OPB_RNW ? rd_data : '0;
          xack_n  = 1'b1;
          sel_n   = '0;
          state_n = DONE;
        end else if (tmo) begin
          eack_n  = 1'b1;
          ecnt_n  = ecnt_inc;
          sel_n   = '0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: begin
        sel_n   = '0;
        state_n = IDLE;
      end
    endcase
    tsup_n = (state_n == ACTIVE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      S_select   <= '0;
      Sl_DBus    <= '0;
      Sl_xferAck <= 1'b0;
      Sl_errAck  <= 1'b0;
      Sl_toutSup <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx_q      <= idx_n;
      S_select   <= sel_n;
      Sl_DBus    <= dbus_n;
      Sl_xferAck <= xack_n;
      Sl_errAck  <= eack_n;
      Sl_toutSup <= tsup_n;
      err_cnt    <= ecnt_n;
    end
  end

endmodule

// File: doc/opb_slave_mux.md
# opb_slave_mux

Arbitrating address decoder that shares one OPB slave port among `C_NUM_SLAVES` register-style OPB slaves, such as ppc2simulink/simulink2ppc registers. It sits between the OPB bus and those slaves. For each transfer it:
- decodes `OPB_ABus` and drives a one-hot registered select to exactly one slave;
- returns that slave's data and ack to the bus;
- converts a slave that never acks into an `Sl_errAck` before the bus timeout fires.

`OPB_DBus` and `OPB_BE` are broadcast to the slaves outside this block.

## Interface
Parameters:
- `C_BASEADDR`, 32'h01000000, base of the first slave window; aligned to the full window.
- `C_NUM_SLAVES`, 4, number of downstream slaves (1..16).
- `C_SPAN_LOG2`, 8, log2 of the bytes per slave window (256 B, e.g. 0x...600–0x...6FF).
- `C_TIMEOUT`, 12, cycles to wait for a slave ack before erroring (2..14, below the OPB 16-cycle bus timeout).

Ports:
- `OPB_Clk`  in  1  sole clock.
- `OPB_Rst`  in  1  reset, asynchronous, active-high.
- `OPB_ABus`  in  [0:31]  bus address.
- `OPB_select`  in  1  bus transfer valid.
- `OPB_RNW`  in  1  1 = read.
- `Sl_DBus`  out  [0:31]  read data to bus; zero when not acking.
- `Sl_xferAck`  out  1  transfer complete.
- `Sl_errAck`  out  1  transfer error.
- `Sl_retry`  out  1  tied 0.
- `Sl_toutSup`  out  1  bus-timeout suppress.
- `S_select`  out  [C_NUM_SLAVES-1:0]  one-hot select to slaves.
- `S_DBus`  in  [C_NUM_SLAVES*32-1:0]  slave k read data in bits [32k+31:32k].
- `S_xferAck`  in  [C_NUM_SLAVES-1:0]  per-slave ack.
- `err_cnt`  out  16  saturating count of timeouts and bad-index errors.

## Operation
- Window hit:
  - `OPB_ABus[0:31-C_SPAN_LOG2-4]` equals the matching bits of `C_BASEADDR`.
  - Slave index `idx` is the 4-bit field immediately above the span bits.
  - An address outside the window is ignored: no outputs change.
- FSM states:
  - `IDLE`
  - `ACTIVE` (slave selected, counter running)
  - `DONE` (one-cycle holdoff while the master drops `OPB_select`)
- `IDLE` transitions, when `OPB_select` is high and the address hits the window:
  - `idx` < `C_NUM_SLAVES`: latch `idx`, set `S_select[idx]`, clear the counter, go to `ACTIVE`.
  - `idx` ≥ `C_NUM_SLAVES`: pulse `Sl_errAck`, increment `err_cnt`, go to `DONE`.
- `ACTIVE` transitions:
  - `S_xferAck[idx]` high: register `S_DBus` slice `idx` to `Sl_DBus` (reads only; writes return 0), pulse `Sl_xferAck`, clear `S_select`, go to `DONE`.
  - Otherwise the counter increments. When it reaches `C_TIMEOUT`: pulse `Sl_errAck`, increment `err_cnt`, clear `S_select`, go to `DONE`.
  - `OPB_select` low (master abort): clear `S_select`, go to `IDLE`, no ack of any kind.
- `DONE`: unconditionally go to `IDLE`.
- Ack and timeout in the same cycle: the ack wins; no error is raised.
- `S_xferAck` from a non-selected slave: ignored.
- `Sl_toutSup` is high whenever the state is `ACTIVE`.
- `err_cnt` saturates at 16'hFFFF and is cleared only by reset.

## Timing
- Reset values: all outputs 0, state `IDLE`, counter 0, `err_cnt` 0.
- Reset is asynchronous, so it takes effect mid-transfer: the state returns to `IDLE` and `S_select` clears immediately.
- All outputs are registered.
- With `OPB_select` high in cycle n:
  - `S_select` is high from cycle n+1.
  - A slave ack in cycle m gives `Sl_xferAck` and `Sl_DBus` in cycle m+1, for exactly 1 cycle.
  - Minimum latency is 2 cycles (m = n+1).
- Timeout: with no ack in cycles n+1 .. n+C_TIMEOUT, `Sl_errAck` is high in cycle n+1+C_TIMEOUT.
- Bad index: `Sl_errAck` is high in cycle n+1.
- Back-to-back transfers: the next `OPB_select` is sampled no earlier than 2 cycles after the ack (`DONE` then `IDLE`).

## Structure
- Package `opb_pkg` holds:
  - the OPB width constants (AWIDTH = DWIDTH = 32);
  - the FSM state enum {IDLE, ACTIVE, DONE};
  - the `err_cnt` width.
- Sub-module `opb_addr_decode`: purely combinational; outputs `hit`, `idx`, `idx_valid` from `OPB_ABus` and the parameters.
- The top level holds the FSM, timeout counter, data/ack registers and error counter.

## Test plan
All scenarios use the default parameters (4 slaves, 256 B windows, base 0x01000000).
- Read at 0x01000208, slave 2 acks 3 cycles after its select with data 0xDEADBEEF:
  - `S_select` = 4'b0100 for 3 cycles;
  - `Sl_xferAck` 1 cycle with `Sl_DBus` = 0xDEADBEEF;
  - `Sl_DBus` returns to 0.
- Write at 0x01000004, slave 0 acks immediately:
  - `Sl_xferAck` at n+2;
  - `Sl_DBus` = 0.
- Read at 0x01000300, slave 3 never acks:
  - `Sl_toutSup` high for 12 cycles;
  - `Sl_errAck` at n+13;
  - `err_cnt` = 1.
- Access to 0x02000000:
  - all outputs stay 0 for 20 cycles.
- Ack and timeout coincide (slave 1 acks on counter = 12):
  - `Sl_xferAck` = 1, `Sl_errAck` = 0, `err_cnt` unchanged.
- Master drops `OPB_select` at n+3, then `OPB_Rst` asserted mid-`ACTIVE` on a second transfer:
  - no ack on either transfer;
  - `S_select` = 0 immediately;
  - the next read to slave 1 completes normally.
